addi_exec_datapath: RTL and testbench

//   Single-cycle execute datapath of the NPC core: decode, ALU and register file in one block.

---
 rtl/addi_exec_datapath.sv | 73 +++++++
 tb/tb_addi_exec_datapath.sv | 135 +++++++++++++
 2 files changed

// File: rtl/addi_exec_datapath.sv
// rtl/addi_exec_datapath.sv - single-cycle ADDI decode, ALU and 32-entry register file
module addi_exec_datapath #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst,
  output logic [XLEN-1:0]   alu_result,
  output logic              reg_wen,
  output logic              illegal,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [XLEN-1:0]   dbg_rdata
);

  localparam int          NREG        = 2 ** REG_AW;
  localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
  localparam logic [2:0]  F3_ADDI     = 3'b000;

  // Instruction fields
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   src1;

  // Architectural registers; entry 0 is never written and is masked on read
  logic [XLEN-1:0]   rf [NREG];

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign rs1    = inst[15 +: REG_AW];
  assign rd     = inst[7 +: REG_AW];
  assign imm    = {{(XLEN-12){inst[31]}}, inst[31:20]};

  // Decode: only OP-IMM with funct3 of ADDI is accepted, everything else is illegal
  always_comb begin
    reg_wen = 1'b0;
    illegal = 1'b1;
    if (opcode == OPC_OP_IMM && funct3 == F3_ADDI) begin
      reg_wen = 1'b1;
      illegal = 1'b0;
    end
  end

  // Asynchronous read ports; x0 always reads as zero even before the first reset
  always_comb begin
    src1      = '0;
    dbg_rdata = '0;
    if (rs1 != '0) begin
      src1 = rf[rs1];
    end
    if (dbg_raddr != '0) begin
      dbg_rdata = rf[dbg_raddr];
    end
  end

  // ALU: modular add, driven regardless of legality
  assign alu_result = src1 + imm;

  // Register file update: reset clears everything and overrides the write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (reg_wen && rd != '0) begin
      rf[rd] <= alu_result;
    end
  end

endmodule

// File: tb/tb_addi_exec_datapath.sv
// tb/tb_addi_exec_datapath.sv - randomized self-checking bench for addi_exec_datapath
module tb_addi_exec_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] alu_result;
  logic        reg_wen;
  logic        illegal;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [32];

  addi_exec_datapath #(.XLEN(32), .REG_AW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .alu_result (alu_result),
    .reg_wen    (reg_wen),
    .illegal    (illegal),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_addi(input logic [31:0] i);
    return (i[6:0] == 7'h13) && (i[14:12] == 3'd0);
  endfunction

  function automatic logic [31:0] ref_sum(input logic [31:0] i);
    int imm_val;
    logic [31:0] r;
    imm_val = $signed(i[31:20]);
    r = model[i[19:15]] + imm_val;
    return r;
  endfunction

  // Called 1ns after a rising edge; leaves 1ns after the next rising edge
  task automatic step(input logic [31:0] i, input logic r, input logic [4:0] da);
    logic [31:0] sum;
    bit legal;
    inst      = i;
    rst       = r;
    dbg_raddr = da;
    legal     = is_addi(i);
    sum       = ref_sum(i);
    @(negedge clk);
    check("alu_result", alu_result, sum);
    check("reg_wen", {31'd0, reg_wen}, {31'd0, legal});
    check("illegal", {31'd0, illegal}, {31'd0, !legal});
    check("dbg_rdata", dbg_rdata, model[da]);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 32; k++) model[k] = 32'd0;
    end else if (legal && i[11:7] != 5'd0) begin
      model[i[11:7]] = sum;
    end
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_raddr = a;
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  initial begin
    logic [31:0] ri;
    logic        rr;
    for (int k = 0; k < 32; k++) model[k] = 32'd0;
    rst       = 1'b1;
    inst      = 32'd0;
    dbg_raddr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 32; a++) check_reg("reset_sweep", 5'(a), 32'd0);
    @(posedge clk);
    #1;

    step(32'h00500093, 1'b0, 5'd1);
    check_reg("addi_x1_5", 5'd1, 32'd5);
    step(32'hFFF08113, 1'b0, 5'd1);
    check_reg("addi_x2_x1_m1", 5'd2, 32'd4);
    step(32'hFFF00113, 1'b0, 5'd2);
    check_reg("addi_x2_m1", 5'd2, 32'hFFFFFFFF);
    step(32'h00110113, 1'b0, 5'd2);
    check_reg("wrap_to_zero", 5'd2, 32'd0);
    step(32'h00700013, 1'b0, 5'd0);
    check_reg("x0_hardwired", 5'd0, 32'd0);
    step(32'h00000033, 1'b0, 5'd1);
    check_reg("illegal_add_nowrite", 5'd1, 32'd5);
    step(32'h00501093, 1'b0, 5'd1);
    check_reg("illegal_f3_nowrite", 5'd1, 32'd5);
    step(32'h00118193, 1'b0, 5'd3);
    check_reg("x3_inc1", 5'd3, 32'd1);
    step(32'h00118193, 1'b0, 5'd3);
    check_reg("x3_inc2", 5'd3, 32'd2);
    step(32'h00118193, 1'b0, 5'd3);
    check_reg("x3_inc3", 5'd3, 32'd3);
    step(32'h00118193, 1'b1, 5'd3);
    check_reg("x3_after_rst", 5'd3, 32'd0);
    check_reg("x1_after_rst", 5'd1, 32'd0);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(3) != 0) begin
        ri = $urandom;
        ri[6:0]   = 7'h13;
        ri[14:12] = 3'd0;
      end else begin
        ri = $urandom;
      end
      rr = ($urandom_range(24) == 0);
      step(ri, rr, 5'($urandom_range(31)));
    end

    for (int a = 0; a < 32; a++) check_reg("final_sweep", 5'(a), model[a]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
